// File: rtl/layer_4_channel_packer.sv
// Assembles a serial stream of per-channel words into one channel-packed pixel word,
// tracking row/column position, frame completion and start-of-frame violations.
module layer_4_channel_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 32,
    parameter int IMG_SIZE   = 104
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            valid_in,
    input  logic                            sof_in,
    output logic [DATA_WIDTH*NUM_CH-1:0]    data_out,
    output logic                            valid_out,
    output logic [$clog2(IMG_SIZE)-1:0]     row_out,
    output logic [$clog2(IMG_SIZE)-1:0]     col_out,
    output logic                            frame_done,
    output logic                            sync_err,
    output logic                            dbg_state
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int POS_W = $clog2(IMG_SIZE);
    localparam int OUT_W = DATA_WIDTH * NUM_CH;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(IMG_SIZE - 1);

    // Handshake: a word is consumed on every rising edge where valid_in is high;
    // there is no backpressure, and sof_in is only meaningful together with valid_in.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [CH_W-1:0]        ch_cnt;
    logic [POS_W-1:0]       row;
    logic [POS_W-1:0]       col;
    logic [DATA_WIDTH-1:0]  stage_q [NUM_CH-1];
    logic [OUT_W-1:0]       packed_pixel;

    logic accept_sof;
    logic accept_data;
    logic pixel_last;
    logic frame_last;

    assign accept_sof  = valid_in && sof_in;
    assign accept_data = valid_in && !sof_in && (state == RUN);
    assign pixel_last  = accept_data && (ch_cnt == LAST_CH);
    assign frame_last  = pixel_last && (row == LAST_POS) && (col == LAST_POS);
    assign dbg_state   = state;

    // The final channel bypasses staging so the pixel is emitted on the accepting edge.
    always_comb begin
        packed_pixel = '0;
        for (int k = 0; k < NUM_CH - 1; k++) begin
            packed_pixel[k*DATA_WIDTH +: DATA_WIDTH] = stage_q[k];
        end
        packed_pixel[OUT_W-1 -: DATA_WIDTH] = data_in;
    end

    // Staging carries no reset: every slot is rewritten before it is ever packed.
    always_ff @(posedge Clk) begin
        if (accept_sof) begin
            stage_q[0] <= data_in;
        end else if (accept_data && !pixel_last) begin
            stage_q[ch_cnt] <= data_in;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= IDLE;
            ch_cnt     <= '0;
            row        <= '0;
            col        <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            row_out    <= '0;
            col_out    <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (accept_sof) begin
                // A sof while a frame is open aborts it and restarts at pixel (0,0).
                sync_err <= (state == RUN);
                ch_cnt   <= CH_W'(1);
                row      <= '0;
                col      <= '0;
                state    <= RUN;
            end else if (accept_data) begin
                if (pixel_last) begin
                    data_out  <= packed_pixel;
                    valid_out <= 1'b1;
                    row_out   <= row;
                    col_out   <= col;
                    ch_cnt    <= '0;
                    if (frame_last) begin
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        row        <= '0;
                        col        <= '0;
                    end else if (col == LAST_POS) begin
                        col <= '0;
                        row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end else begin
                    ch_cnt <= ch_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/layer_4_channel_packer.md
# layer_4_channel_packer

Front end of the layer-4 featuremap pipeline. Takes a serial stream of 32-bit channel words, 32 channels per pixel, pixels in raster order. Assembles each pixel into one 1024-bit channel-packed word with a single-cycle valid strobe. This is the slice layout and valid_in/data_in convention consumed by the layer-4 featuremap convolution blocks. The block also tracks row and column position and flags frame completion and framing errors.

## Interface
Parameters:
- DATA_WIDTH, 32: width of one channel word (IEEE-754 single).
- NUM_CH, 32: channels per pixel.
- IMG_SIZE, 104: feature-map width and height in pixels.

Ports:
- Clk  in  1  single clock; all state updates on rising edge.
- Rst  in  1  reset, asynchronous and active-low (0 = reset).
- data_in  in  DATA_WIDTH  one channel word.
- valid_in  in  1  data_in is valid this cycle; a word is accepted every cycle it is high (no backpressure).
- sof_in  in  1  start of frame; qualified by valid_in; marks channel 0 of pixel (0,0).
- data_out  out  DATA_WIDTH*NUM_CH  packed pixel; channel k in bits [32k+31:32k].
- valid_out  out  1  one-cycle strobe: data_out holds a new complete pixel.
- row_out  out  clog2(IMG_SIZE)  row of the pixel on data_out.
- col_out  out  clog2(IMG_SIZE)  column of the pixel on data_out.
- frame_done  out  1  one-cycle strobe, coincident with valid_out of the last pixel (row = col = IMG_SIZE-1).
- sync_err  out  1  one-cycle strobe on a framing violation.

## Operation
- States: IDLE and RUN.
- IDLE:
  - Accepted words with sof_in=0 are dropped. No error is flagged.
  - An accepted word with sof_in=1 is stored as channel 0. ch_cnt becomes 1, row and col are cleared, and the state goes to RUN.
- RUN, accepted word with sof_in=0:
  - The word is written into staging slot ch_cnt.
  - ch_cnt then increments.
- Pixel completion, when the word with ch_cnt = NUM_CH-1 is accepted:
  - data_out receives the staging slots 0..NUM_CH-2 together with the current word in slot NUM_CH-1.
  - valid_out, row_out and col_out are registered.
  - ch_cnt wraps to 0.
  - col increments. At IMG_SIZE-1, col wraps to 0 and row increments.
- Frame completion: completing pixel (IMG_SIZE-1, IMG_SIZE-1) asserts frame_done and returns the state to IDLE.
- sof_in=1 on an accepted word in RUN is always a violation, including at a pixel boundary:
  - sync_err pulses.
  - The partial pixel and the frame are discarded; frame_done is not asserted.
  - The word becomes channel 0 of pixel (0,0) of a new frame; the state stays RUN.
- valid_in low: nothing changes. Gaps of any length are allowed between words, including mid-pixel.
- data_out, row_out and col_out hold their value between strobes.
- Staging slots are not cleared between pixels; every slot is overwritten before the next completion.

## Timing
- Reset (Rst=0, asynchronous): state IDLE, all counters 0, data_out 0, valid_out 0, row_out 0, col_out 0, frame_done 0, sync_err 0.
- Reset takes effect immediately, even mid-pixel or mid-frame. Partial data is lost.
- After Rst deasserts, the first accepted sof_in word starts a frame.
- Latency: valid_out rises on the cycle after the edge that accepts channel NUM_CH-1. data_out is valid in that same cycle.
- Throughput: one pixel per NUM_CH accepted words. Back-to-back pixels with continuous valid_in give one valid_out every NUM_CH cycles.
- sync_err is registered; it rises the cycle after the offending word is accepted.
- Counter wrap: ch_cnt NUM_CH-1 → 0; col IMG_SIZE-1 → 0 with row+1; row does not wrap, because the frame ends first.
- valid_out and frame_done are never high for more than one consecutive cycle.

## Test plan
- Reset, then one frame of IMG_SIZE² × 32 words with continuous valid_in, where word value = {row[7:0], col[7:0], ch[15:0]}:
  - 10816 valid_out strobes, one every 32 cycles.
  - data_out slot k = {row, col, k}, and row_out/col_out match.
  - frame_done exactly once, on the last strobe; state back to IDLE.
- Same frame with valid_in toggling randomly at 50%: identical output sequence; strobes only on 32nd-word acceptance.
- Words without sof_in while IDLE, then a correct frame: no valid_out and no sync_err before sof; the frame packs correctly.
- sof_in at word 17 of pixel (3,5): sync_err pulses once; no strobe for the partial pixel; the next strobe is pixel (0,0) built from that sof word; no frame_done for the aborted frame.
- Rst pulsed low for one cycle mid-pixel, asynchronously between edges: all outputs 0 immediately; the next frame starting with sof packs correctly.
- IMG_SIZE=2, NUM_CH=4: frame_done on the 4th strobe, with row_out=col_out=1; a second frame sent back-to-back with sof gives no sync_err.
